// File: rtl/sad_search_ctrl_pkg.sv
// rtl/sad_search_ctrl_pkg.sv - shared motion-estimation types, defaults and helpers
package sad_search_ctrl_pkg;

  localparam int SR_DEF       = 16;
  localparam int PIPE_LAT_DEF = 4;
  localparam int MVW_DEF      = 6;
  localparam int CAND_CNT_W   = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SEARCH,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic int cand_total(input int sr);
    return (2 * sr + 1) * (2 * sr + 1);
  endfunction

  // Bits needed to hold the full candidate count of one search.
  function automatic int cand_cnt_w(input int sr);
    return $clog2(cand_total(sr) + 1);
  endfunction

endpackage

// File: rtl/sad_search_ctrl_if.sv
// rtl/sad_search_ctrl_if.sv - start/ref handshake and candidate/comparator bus
interface sad_search_ctrl_if #(
  parameter int MVW = sad_search_ctrl_pkg::MVW_DEF
);

  logic                                        start;
  logic                                        ref_ready;
  logic                                        busy;
  logic                                        done;
  logic                                        min_clr;
  logic                                        cand_valid;
  logic signed [MVW-1:0]                       cand_mvx;
  logic signed [MVW-1:0]                       cand_mvy;
  logic                                        cmp_en;
  logic signed [MVW-1:0]                       cmp_mvx;
  logic signed [MVW-1:0]                       cmp_mvy;
  logic [sad_search_ctrl_pkg::CAND_CNT_W-1:0]  cand_cnt;

  modport slave (
    input  start, ref_ready,
    output busy, done, min_clr, cand_valid, cand_mvx, cand_mvy,
           cmp_en, cmp_mvx, cmp_mvy, cand_cnt
  );

  modport master (
    output start, ref_ready,
    input  busy, done, min_clr, cand_valid, cand_mvx, cand_mvy,
           cmp_en, cmp_mvx, cmp_mvy, cand_cnt
  );

endinterface

// File: rtl/sad_search_ctrl_delay.sv
// rtl/sad_search_ctrl_delay.sv - free-running shift register with synchronous clear
module me_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sad_search_ctrl.sv
// rtl/sad_search_ctrl.sv - full-search raster candidate issue and SAD pipeline alignment
module sad_search_ctrl
  import sad_search_ctrl_pkg::*;
#(
  parameter int SR       = SR_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF,
  parameter int MVW      = MVW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  sad_search_ctrl_if.slave   bus
);

  localparam int CW  = cand_cnt_w(SR);
  localparam int DW  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int DLW = 1 + 2 * MVW;

  localparam logic signed [MVW-1:0] MV_MIN     = MVW'(-SR);
  localparam logic signed [MVW-1:0] MV_MAX     = MVW'(SR);
  localparam logic signed [MVW-1:0] MV_ONE     = MVW'(1);
  localparam logic [DW-1:0]         DRAIN_LAST = DW'(PIPE_LAT - 1);

  state_e                state_q, state_d;
  logic signed [MVW-1:0] mvx_q, mvx_d, mvy_q, mvy_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         drain_q, drain_d;
  logic                  issue;

  logic                  busy_q, done_q, min_clr_q, cand_valid_q;
  logic signed [MVW-1:0] cand_mvx_q, cand_mvy_q;

  logic [DLW-1:0]        dl_d, dl_q;

  always_comb begin
    state_d = state_q;
    mvx_d   = mvx_q;
    mvy_d   = mvy_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        mvx_d   = MV_MIN;
        mvy_d   = MV_MIN;
        cnt_d   = '0;
        state_d = ST_SEARCH;
      end
      ST_SEARCH: begin
        if (bus.ref_ready) begin
          issue = 1'b1;
          cnt_d = cnt_q + CW'(1);
          if (mvx_q == MV_MAX) begin
            mvx_d = MV_MIN;
            if (mvy_q == MV_MAX) begin
              state_d = ST_DRAIN;
              drain_d = '0;
            end else begin
              mvy_d = mvy_q + MV_ONE;
            end
          end else begin
            mvx_d = mvx_q + MV_ONE;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = ST_DONE;
        else                       drain_d = drain_q + DW'(1);
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Status outputs are flopped decodes of the current state, one cycle behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mvx_q        <= '0;
      mvy_q        <= '0;
      cnt_q        <= '0;
      drain_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      min_clr_q    <= 1'b0;
      cand_valid_q <= 1'b0;
      cand_mvx_q   <= '0;
      cand_mvy_q   <= '0;
    end else begin
      state_q      <= state_d;
      mvx_q        <= mvx_d;
      mvy_q        <= mvy_d;
      cnt_q        <= cnt_d;
      drain_q      <= drain_d;
      busy_q       <= (state_q != ST_IDLE);
      done_q       <= (state_q == ST_DONE);
      min_clr_q    <= (state_q == ST_CLEAR);
      cand_valid_q <= issue;
      cand_mvx_q   <= issue ? mvx_q : '0;
      cand_mvy_q   <= issue ? mvy_q : '0;
    end
  end

  assign dl_d = {cand_valid_q, cand_mvx_q, cand_mvy_q};

  me_delay_line #(
    .WIDTH (DLW),
    .DEPTH (PIPE_LAT)
  ) u_dly (
    .clk   (clk),
    .clr_i (rst),
    .d_i   (dl_d),
    .q_o   (dl_q)
  );

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.min_clr    = min_clr_q;
  assign bus.cand_valid = cand_valid_q;
  assign bus.cand_mvx   = cand_mvx_q;
  assign bus.cand_mvy   = cand_mvy_q;
  assign bus.cmp_en     = dl_q[DLW-1];
  assign bus.cmp_mvx    = dl_q[2*MVW-1:MVW];
  assign bus.cmp_mvy    = dl_q[MVW-1:0];
  assign bus.cand_cnt   = CAND_CNT_W'(cnt_q);

endmodule

// File: tb/tb_sad_search_ctrl.sv
// tb/tb_sad_search_ctrl.sv - directed and scoreboard bench for sad_search_ctrl
module tb_sad_search_ctrl;

  localparam int NC = 80;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sad_search_ctrl_if #(.MVW(6)) bus_s ();
  sad_search_ctrl_if #(.MVW(6)) bus_l ();

  sad_search_ctrl #(.SR(2), .PIPE_LAT(3), .MVW(6)) dut_s (.clk(clk), .rst(rst), .bus(bus_s));
  sad_search_ctrl #(.SR(16), .PIPE_LAT(4), .MVW(6)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

  int n_tests = 0;
  int n_fail  = 0;

  logic              c_valid[NC], c_cmp[NC], c_done[NC], c_clr[NC], c_busy[NC];
  logic signed [5:0] c_mx[NC], c_my[NC], c_cx[NC], c_cy[NC];
  logic [11:0]       c_cnt[NC];

  bit e_valid[NC], e_cmp[NC];
  int e_mx[NC], e_my[NC], e_cx[NC], e_cy[NC], e_cnt[NC];
  int e_done;

  logic              iv[4096];
  logic signed [5:0] ix[4096], iy[4096];

  task automatic run_small(input int ncyc, input int s0, input int s1, input int s2,
                           input int lo, input int hi, input int rc);
    for (int k = 0; k < ncyc; k++) begin
      bus_s.start     = (k == s0) || (k == s1) || (k == s2);
      bus_s.ref_ready = !(k >= lo && k <= hi);
      rst             = (k == rc);
      @(posedge clk); #1;
      c_valid[k] = bus_s.cand_valid;  c_mx[k] = bus_s.cand_mvx;  c_my[k] = bus_s.cand_mvy;
      c_cmp[k]   = bus_s.cmp_en;      c_cx[k] = bus_s.cmp_mvx;   c_cy[k] = bus_s.cmp_mvy;
      c_done[k]  = bus_s.done;        c_clr[k] = bus_s.min_clr;  c_busy[k] = bus_s.busy;
      c_cnt[k]   = bus_s.cand_cnt;
    end
    bus_s.start = 1'b0; bus_s.ref_ready = 1'b1; rst = 1'b0;
  endtask

  // Reference schedule for SR=2, PIPE_LAT=3, start in cycle 0, ref_ready low in lo..hi.
  task automatic build_exp(input int lo, input int hi);
    int idx;
    int last;
    idx = 0; last = -1;
    for (int k = 0; k < NC; k++) begin
      e_valid[k] = 1'b0; e_mx[k] = 0; e_my[k] = 0;
      if (k >= 2 && idx < 25 && !(k >= lo && k <= hi)) begin
        e_valid[k] = 1'b1; e_mx[k] = -2 + idx % 5; e_my[k] = -2 + idx / 5;
        idx++; last = k;
      end
      e_cnt[k] = idx;
    end
    e_done = last + 4;
    for (int k = 0; k < NC; k++) begin
      e_cmp[k] = (k >= 3) ? e_valid[k-3] : 1'b0;
      e_cx[k]  = (k >= 3) ? e_mx[k-3] : 0;
      e_cy[k]  = (k >= 3) ? e_my[k-3] : 0;
    end
  endtask

  task automatic test_reset();
    bus_s.start = 1'b1; bus_s.ref_ready = 1'b1;
    bus_l.start = 1'b1; bus_l.ref_ready = 1'b1;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({bus_s.busy, bus_s.done, bus_s.min_clr, bus_s.cand_valid, bus_s.cmp_en} !== 5'b0 ||
          bus_s.cand_mvx !== 6'sd0 || bus_s.cand_mvy !== 6'sd0 || bus_s.cmp_mvx !== 6'sd0 ||
          bus_s.cmp_mvy !== 6'sd0 || bus_s.cand_cnt !== 12'd0 ||
          {bus_l.busy, bus_l.done, bus_l.min_clr, bus_l.cand_valid, bus_l.cmp_en} !== 5'b0 ||
          bus_l.cand_cnt !== 12'd0) begin
        n_fail++;
        $display("FAIL reset_state cyc %0d: small busy/done/clr/valid/cmp=%b%b%b%b%b cnt=%0d large cnt=%0d, required all 0",
                 k, bus_s.busy, bus_s.done, bus_s.min_clr, bus_s.cand_valid, bus_s.cmp_en,
                 bus_s.cand_cnt, bus_l.cand_cnt);
      end
    end
    bus_s.start = 1'b0; bus_l.start = 1'b0; rst = 1'b0;
  endtask

  task automatic test_nominal();
    build_exp(-1, -1);
    run_small(40, 0, -1, -1, -1, -1, -1);
    for (int k = 0; k < 40; k++) begin
      n_tests++;
      if (c_valid[k] !== e_valid[k] || c_mx[k] !== e_mx[k] || c_my[k] !== e_my[k] ||
          c_cmp[k] !== e_cmp[k] || c_cx[k] !== e_cx[k] || c_cy[k] !== e_cy[k] ||
          c_clr[k] !== (k == 1) || c_done[k] !== (k == e_done) ||
          c_busy[k] !== (k >= 1 && k <= e_done) || (k >= 1 && c_cnt[k] !== e_cnt[k])) begin
        n_fail++;
        $display("FAIL nominal cyc %0d: got v=%b (%0d,%0d) cmp=%b (%0d,%0d) clr=%b done=%b busy=%b cnt=%0d; need v=%b (%0d,%0d) cmp=%b (%0d,%0d) clr=%b done=%b cnt=%0d",
                 k, c_valid[k], c_mx[k], c_my[k], c_cmp[k], c_cx[k], c_cy[k], c_clr[k], c_done[k],
                 c_busy[k], c_cnt[k], e_valid[k], e_mx[k], e_my[k], e_cmp[k], e_cx[k], e_cy[k],
                 k == 1, k == e_done, e_cnt[k]);
      end
    end
    n_tests++;
    if (c_mx[2] !== -6'sd2 || c_my[2] !== -6'sd2 || c_mx[7] !== -6'sd2 || c_my[7] !== -6'sd1 ||
        c_mx[26] !== 6'sd2 || c_my[26] !== 6'sd2) begin
      n_fail++;
      $display("FAIL nominal_key_mvs: got (%0d,%0d) (%0d,%0d) (%0d,%0d), need (-2,-2) (-2,-1) (2,2)",
               c_mx[2], c_my[2], c_mx[7], c_my[7], c_mx[26], c_my[26]);
    end
    n_tests++;
    if (c_done[30] !== 1'b1 || c_cmp[29] !== 1'b1 || c_cmp[30] !== 1'b0 || c_cmp[5] !== 1'b1 ||
        c_cmp[4] !== 1'b0 || c_cnt[39] !== 12'd25) begin
      n_fail++;
      $display("FAIL nominal_timing: done30=%b cmp4/5/29/30=%b%b%b%b cnt=%0d, need 1 0110 25",
               c_done[30], c_cmp[4], c_cmp[5], c_cmp[29], c_cmp[30], c_cnt[39]);
    end
  endtask

  task automatic test_stall();
    build_exp(4, 6);
    run_small(44, 0, -1, -1, 4, 6, -1);
    for (int k = 0; k < 44; k++) begin
      n_tests++;
      if (c_valid[k] !== e_valid[k] || c_mx[k] !== e_mx[k] || c_my[k] !== e_my[k] ||
          c_cmp[k] !== e_cmp[k] || c_cx[k] !== e_cx[k] || c_cy[k] !== e_cy[k] ||
          c_done[k] !== (k == e_done) || (k >= 1 && c_cnt[k] !== e_cnt[k])) begin
        n_fail++;
        $display("FAIL stall cyc %0d: got v=%b (%0d,%0d) cmp=%b (%0d,%0d) done=%b cnt=%0d; need v=%b (%0d,%0d) cmp=%b (%0d,%0d) done=%b cnt=%0d",
                 k, c_valid[k], c_mx[k], c_my[k], c_cmp[k], c_cx[k], c_cy[k], c_done[k], c_cnt[k],
                 e_valid[k], e_mx[k], e_my[k], e_cmp[k], e_cx[k], e_cy[k], k == e_done, e_cnt[k]);
      end
    end
    n_tests++;
    if (c_valid[7] !== 1'b1 || c_mx[7] !== 6'sd0 || c_my[7] !== -6'sd2 || c_done[33] !== 1'b1 ||
        c_valid[5] !== 1'b0 || c_cnt[5] !== 12'd2) begin
      n_fail++;
      $display("FAIL stall_key: v7=%b mv7=(%0d,%0d) done33=%b v5=%b cnt5=%0d, need 1 (0,-2) 1 0 2",
               c_valid[7], c_mx[7], c_my[7], c_done[33], c_valid[5], c_cnt[5]);
    end
  endtask

  task automatic test_start_ignored();
    int nd, nc, nv, bad;
    build_exp(-1, -1);
    run_small(40, 0, 10, 30, -1, -1, -1);
    nd = 0; nc = 0; nv = 0; bad = 0;
    for (int k = 0; k < 40; k++) begin
      nd += int'(c_done[k]); nc += int'(c_clr[k]); nv += int'(c_valid[k]);
      if (c_valid[k] !== e_valid[k] || c_mx[k] !== e_mx[k] || c_my[k] !== e_my[k]) bad++;
    end
    n_tests++;
    if (nd != 1 || nc != 1 || nv != 25 || bad != 0 || c_done[30] !== 1'b1) begin
      n_fail++;
      $display("FAIL start_ignored: dones=%0d clrs=%0d cands=%0d mv_errs=%0d done30=%b, need 1 1 25 0 1",
               nd, nc, nv, bad, c_done[30]);
    end
    n_tests++;
    if (c_busy[31] !== 1'b0 || c_clr[32] !== 1'b0) begin
      n_fail++;
      $display("FAIL start_at_done_return: busy31=%b clr32=%b, need 0 0", c_busy[31], c_clr[32]);
    end
  endtask

  task automatic test_back_to_back();
    int nd, nv;
    run_small(70, 0, 31, -1, -1, -1, -1);
    nd = 0; nv = 0;
    for (int k = 0; k < 70; k++) begin
      nd += int'(c_done[k]); nv += int'(c_valid[k]);
    end
    n_tests++;
    if (nd != 2 || nv != 50 || c_clr[32] !== 1'b1 || c_done[61] !== 1'b1 || c_busy[31] !== 1'b0 ||
        c_valid[33] !== 1'b1 || c_mx[33] !== -6'sd2 || c_my[33] !== -6'sd2 || c_cnt[69] !== 12'd25) begin
      n_fail++;
      $display("FAIL back_to_back: dones=%0d cands=%0d clr32=%b done61=%b busy31=%b v33=%b mv33=(%0d,%0d) cnt=%0d, need 2 50 1 1 0 1 (-2,-2) 25",
               nd, nv, c_clr[32], c_done[61], c_busy[31], c_valid[33], c_mx[33], c_my[33], c_cnt[69]);
    end
  endtask

  task automatic test_reset_mid();
    int late, nd, bad;
    run_small(40, 0, -1, -1, -1, -1, 15);
    n_tests++;
    if (c_valid[14] !== 1'b1 || c_mx[14] !== 6'sd0 || c_my[14] !== 6'sd0) begin
      n_fail++;
      $display("FAIL reset_mid_pre: v14=%b mv=(%0d,%0d), need 1 (0,0)", c_valid[14], c_mx[14], c_my[14]);
    end
    n_tests++;
    if ({c_busy[16], c_done[16], c_clr[16], c_valid[16], c_cmp[16]} !== 5'b0 ||
        c_mx[16] !== 6'sd0 || c_my[16] !== 6'sd0 || c_cx[16] !== 6'sd0 || c_cy[16] !== 6'sd0 ||
        c_cnt[16] !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_mid_c16: busy/done/clr/v/cmp=%b%b%b%b%b cnt=%0d, need all 0",
               c_busy[16], c_done[16], c_clr[16], c_valid[16], c_cmp[16], c_cnt[16]);
    end
    late = 0;
    for (int k = 16; k < 40; k++)
      late += int'(c_done[k]) + int'(c_clr[k]) + int'(c_valid[k]) + int'(c_cmp[k]) + int'(c_busy[k]);
    n_tests++;
    if (late != 0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: %0d active output cycles after reset, need 0", late);
    end
    build_exp(-1, -1);
    run_small(40, 0, -1, -1, -1, -1, -1);
    nd = 0; bad = 0;
    for (int k = 0; k < 40; k++) begin
      nd += int'(c_done[k]);
      if (c_valid[k] !== e_valid[k] || c_mx[k] !== e_mx[k] || c_my[k] !== e_my[k] ||
          c_cmp[k] !== e_cmp[k]) bad++;
    end
    n_tests++;
    if (nd != 1 || bad != 0 || c_done[30] !== 1'b1 || c_cnt[39] !== 12'd25) begin
      n_fail++;
      $display("FAIL reset_restart: dones=%0d errs=%0d done30=%b cnt=%0d, need 1 0 1 25",
               nd, bad, c_done[30], c_cnt[39]);
    end
  endtask

  task automatic test_scoreboard();
    int j, last_cmp, done_cyc, ex, ey;
    bit rdy;
    j = 0; last_cmp = -1; done_cyc = -1;
    for (int k = 0; k < 4000; k++) begin
      rdy = ($urandom_range(0, 3) != 0);
      bus_l.start     = (k == 0);
      bus_l.ref_ready = rdy;
      @(posedge clk); #1;
      iv[k] = bus_l.cand_valid; ix[k] = bus_l.cand_mvx; iy[k] = bus_l.cand_mvy;
      if (!rdy) begin
        n_tests++;
        if (bus_l.cand_valid !== 1'b0 || bus_l.cand_mvx !== 6'sd0 || bus_l.cand_mvy !== 6'sd0) begin
          n_fail++;
          $display("FAIL sb_idle_cand cyc %0d: v=%b mv=(%0d,%0d), need 0 (0,0)",
                   k, bus_l.cand_valid, bus_l.cand_mvx, bus_l.cand_mvy);
        end
      end
      if (bus_l.cmp_en === 1'b1) begin
        ex = -16 + j % 33; ey = -16 + j / 33;
        n_tests++;
        if (k < 4 || iv[(k < 4) ? 0 : k-4] !== 1'b1 || bus_l.cmp_mvx !== ix[(k < 4) ? 0 : k-4] ||
            bus_l.cmp_mvy !== iy[(k < 4) ? 0 : k-4] || bus_l.cmp_mvx !== ex || bus_l.cmp_mvy !== ey) begin
          n_fail++;
          $display("FAIL sb_cmp #%0d cyc %0d: cmp=(%0d,%0d) need raster (%0d,%0d) and cand 4 cycles earlier",
                   j, k, bus_l.cmp_mvx, bus_l.cmp_mvy, ex, ey);
        end
        j++; last_cmp = k;
      end
      if (bus_l.done === 1'b1) begin
        done_cyc = k;
        break;
      end
    end
    bus_l.start = 1'b0; bus_l.ref_ready = 1'b0;
    n_tests++;
    if (done_cyc < 0) begin
      n_fail++;
      $display("FAIL sb_timeout: done not seen in 4000 cycles, required a done");
    end
    n_tests++;
    if (j != 1089 || bus_l.cand_cnt !== 12'd1089) begin
      n_fail++;
      $display("FAIL sb_count: cmp=%0d cand_cnt=%0d, need 1089 1089", j, bus_l.cand_cnt);
    end
    n_tests++;
    if (done_cyc != last_cmp + 1) begin
      n_fail++;
      $display("FAIL sb_done_after_last_cmp: done cyc %0d last cmp cyc %0d, need done = last+1",
               done_cyc, last_cmp);
    end
  endtask

  initial begin
    bus_s.start = 1'b0; bus_s.ref_ready = 1'b1;
    bus_l.start = 1'b0; bus_l.ref_ready = 1'b0;
    rst = 1'b1;
    test_reset();
    test_nominal();
    test_stall();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_scoreboard();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
